// File: rtl/miniscope_pkg.sv
// Shared constants and read-FSM state encoding for the miniscope FIFO controller.
package miniscope_pkg;
   localparam int RAM_ADRB  = 11;
   localparam int RAM_WIDTH = 8;
   localparam int MXTBIN    = 5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
endpackage

// File: rtl/miniscope_wptr.sv
// Free-running circular write pointer: registered write enable plus a wrapping address counter.
module miniscope_wptr
   import miniscope_pkg::*;
#(
   parameter int ADRB = RAM_ADRB
) (
   input  logic            i_clock,
   input  logic            i_reset_n,
   input  logic            i_mini_en,
   output logic            o_wen,
   output logic [ADRB-1:0] o_wadr
);
   logic            r_wen;
   logic [ADRB-1:0] r_wadr;

   // Address advances after each written sample, so it always points at the next slot.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wen  <= 1'b0;
         r_wadr <= '0;
      end else begin
         r_wen <= i_mini_en;
         if (r_wen) r_wadr <= r_wadr + ADRB'(1);
      end
   end

   assign o_wen  = r_wen;
   assign o_wadr = r_wadr;
endmodule

// File: rtl/miniscope_ctrl.sv
// Miniscope FIFO address/sequence controller: write pointer, look-back read sweep and
// read-data alignment toward the DMB readout sequencer.
module miniscope_ctrl #(
   parameter int RAM_ADRB  = miniscope_pkg::RAM_ADRB,
   parameter int RAM_WIDTH = miniscope_pkg::RAM_WIDTH,
   parameter int MXTBIN    = miniscope_pkg::MXTBIN
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   mini_en,
   input  logic                   rd_start,
   input  logic [RAM_ADRB-1:0]    rd_offset,
   input  logic [MXTBIN-1:0]      rd_pretrig,
   input  logic [MXTBIN-1:0]      rd_tbins,
   input  logic [2*RAM_WIDTH-1:0] fifo_rdata_mini,
   output logic                   fifo_wen,
   output logic [RAM_ADRB-1:0]    fifo_wadr_mini,
   output logic [RAM_ADRB-1:0]    fifo_radr_mini,
   output logic [2*RAM_WIDTH-1:0] mini_dout,
   output logic                   mini_dout_vld,
   output logic                   rd_busy,
   output logic                   rd_done,
   output logic                   rd_lookback_err
);
   import miniscope_pkg::*;

   logic [1:0]          r_state;
   logic [RAM_ADRB-1:0] r_radr;
   logic [MXTBIN-1:0]   r_cnt;
   logic                r_vld;
   logic                r_done;
   logic                r_err;

   logic [RAM_ADRB-1:0] w_wadr;
   logic [RAM_ADRB:0]   w_sum;
   logic [RAM_ADRB-1:0] w_start;
   logic                w_accept;
   logic                w_strobe;

   miniscope_wptr #(.ADRB(RAM_ADRB)) u_wptr (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_mini_en (mini_en),
      .o_wen     (fifo_wen),
      .o_wadr    (w_wadr)
   );

   // One extra bit on the sum exposes a look-back deeper than the buffer.
   assign w_sum    = {1'b0, rd_offset} + (RAM_ADRB+1)'(rd_pretrig);
   assign w_start  = w_wadr - rd_offset - RAM_ADRB'(rd_pretrig);
   assign w_accept = rd_start && (r_state == ST_IDLE);
   assign w_strobe = (r_state == ST_READ);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_radr  <= '0;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_vld  <= w_strobe;
         if (w_accept && w_sum[RAM_ADRB]) r_err <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (rd_start) begin
                  if (rd_tbins != '0) begin
                     r_radr  <= w_start;
                     r_cnt   <= rd_tbins;
                     r_state <= ST_READ;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               r_radr <= r_radr + RAM_ADRB'(1);
               r_cnt  <= r_cnt - MXTBIN'(1);
               if (r_cnt == MXTBIN'(1)) r_state <= ST_FLUSH;
            end
            // Last RAM word is still in flight; it lands alongside this state.
            ST_FLUSH: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fifo_wadr_mini  = w_wadr;
   assign fifo_radr_mini  = r_radr;
   assign mini_dout_vld   = r_vld;
   assign mini_dout       = r_vld ? fifo_rdata_mini : '0;
   assign rd_busy         = (r_state != ST_IDLE);
   assign rd_done         = r_done;
   assign rd_lookback_err = r_err;
endmodule

// File: tb/tb_miniscope_ctrl.sv
// Directed bench for miniscope_ctrl with a 1-cycle synchronous RAM holding address-derived data.
module tb_miniscope_ctrl;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        mini_en = 1'b0;
   logic        rd_start = 1'b0;
   logic [10:0] rd_offset = '0;
   logic [4:0]  rd_pretrig = '0;
   logic [4:0]  rd_tbins = '0;
   logic [15:0] fifo_rdata_mini = '0;
   logic        fifo_wen;
   logic [10:0] fifo_wadr_mini;
   logic [10:0] fifo_radr_mini;
   logic [15:0] mini_dout;
   logic        mini_dout_vld;
   logic        rd_busy;
   logic        rd_done;
   logic        rd_lookback_err;

   int n_chk = 0;
   int n_fail = 0;

   miniscope_ctrl dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .mini_en         (mini_en),
      .rd_start        (rd_start),
      .rd_offset       (rd_offset),
      .rd_pretrig      (rd_pretrig),
      .rd_tbins        (rd_tbins),
      .fifo_rdata_mini (fifo_rdata_mini),
      .fifo_wen        (fifo_wen),
      .fifo_wadr_mini  (fifo_wadr_mini),
      .fifo_radr_mini  (fifo_radr_mini),
      .mini_dout       (mini_dout),
      .mini_dout_vld   (mini_dout_vld),
      .rd_busy         (rd_busy),
      .rd_done         (rd_done),
      .rd_lookback_err (rd_lookback_err)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] ram_word(input logic [10:0] a);
      return {5'b10101, a};
   endfunction

   always @(posedge clock) fifo_rdata_mini <= ram_word(fifo_radr_mini);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0; mini_en = 1'b0; rd_start = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic do_read(input string nm, input logic [10:0] off, input logic [4:0] pre,
                          input logic [4:0] tb, input logic [10:0] st, input bit collide);
      int nv;
      logic [10:0] ea;
      nv = 0;
      rd_offset = off; rd_pretrig = pre; rd_tbins = tb; rd_start = 1'b1;
      for (int j = 1; j <= int'(tb) + 6; j++) begin
         @(negedge clock);
         if (j == 1) rd_start = 1'b0;
         if (collide && j == 2) begin
            rd_start = 1'b1; rd_offset = '0; rd_tbins = 5'd20;
         end
         if (collide && j == 3) rd_start = 1'b0;
         if (j <= int'(tb)) begin
            ea = st + 11'(j - 1);
            chk({nm, "_radr"}, 32'(fifo_radr_mini), 32'(ea));
         end
         if (j >= 2 && j <= int'(tb) + 1) begin
            ea = st + 11'(j - 2);
            chk({nm, "_vld"}, 32'(mini_dout_vld), 32'd1);
            chk({nm, "_dout"}, 32'(mini_dout), 32'(ram_word(ea)));
         end else begin
            chk({nm, "_novld"}, 32'(mini_dout_vld), 32'd0);
            chk({nm, "_dout0"}, 32'(mini_dout), 32'd0);
         end
         chk({nm, "_done"}, 32'(rd_done), 32'(j == int'(tb) + 2));
         chk({nm, "_busy"}, 32'(rd_busy), 32'(j <= int'(tb) + 1));
         if (mini_dout_vld) nv++;
      end
      chk({nm, "_count"}, 32'(nv), 32'(tb));
   endtask

   initial begin
      // reset state
      @(negedge clock);
      chk("rst_wen", 32'(fifo_wen), 32'd0);
      chk("rst_wadr", 32'(fifo_wadr_mini), 32'd0);
      chk("rst_radr", 32'(fifo_radr_mini), 32'd0);
      chk("rst_vld", 32'(mini_dout_vld), 32'd0);
      chk("rst_dout", 32'(mini_dout), 32'd0);
      chk("rst_busy", 32'(rd_busy), 32'd0);
      chk("rst_done", 32'(rd_done), 32'd0);
      chk("rst_err", 32'(rd_lookback_err), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // write pointer runs 0..2047 then wraps
      mini_en = 1'b1;
      chk("wen_lag", 32'(fifo_wen), 32'd0);
      for (int k = 0; k < 2050; k++) begin
         @(negedge clock);
         chk("wr_wen", 32'(fifo_wen), 32'd1);
         chk("wr_wadr", 32'(fifo_wadr_mini), 32'(k % 2048));
      end

      // basic readout while writing continues
      do_reset();
      mini_en = 1'b1;
      repeat (101) @(negedge clock);
      chk("basic_wadr", 32'(fifo_wadr_mini), 32'd100);
      do_read("basic", 11'd20, 5'd2, 5'd7, 11'd78, 1'b0);
      chk("basic_err", 32'(rd_lookback_err), 32'd0);

      // freeze write pointer at 5
      do_reset();
      mini_en = 1'b1;
      repeat (5) @(negedge clock);
      mini_en = 1'b0;
      @(negedge clock);
      chk("frz_wadr", 32'(fifo_wadr_mini), 32'd5);
      chk("frz_wen", 32'(fifo_wen), 32'd0);

      do_read("wrap", 11'd8, 5'd0, 5'd6, 11'd2045, 1'b0);
      chk("wrap_err", 32'(rd_lookback_err), 32'd0);
      do_read("edge2047", 11'd2047, 5'd0, 5'd1, 11'd6, 1'b0);
      chk("edge_err", 32'(rd_lookback_err), 32'd0);
      do_read("lberr", 11'd2040, 5'd10, 5'd3, 11'd3, 1'b0);
      chk("lberr_set", 32'(rd_lookback_err), 32'd1);

      // zero time bins: done only
      rd_offset = '0; rd_pretrig = '0; rd_tbins = '0; rd_start = 1'b1;
      @(negedge clock);
      rd_start = 1'b0;
      chk("zero_done", 32'(rd_done), 32'd1);
      chk("zero_busy", 32'(rd_busy), 32'd0);
      chk("zero_vld", 32'(mini_dout_vld), 32'd0);
      @(negedge clock);
      chk("zero_done_clr", 32'(rd_done), 32'd0);
      chk("zero_vld2", 32'(mini_dout_vld), 32'd0);
      chk("err_sticky", 32'(rd_lookback_err), 32'd1);

      do_read("collide", 11'd4, 5'd1, 5'd5, 11'd0, 1'b1);

      // reset on the 3rd data word
      rd_offset = 11'd4; rd_pretrig = '0; rd_tbins = 5'd7; rd_start = 1'b1;
      @(negedge clock);
      rd_start = 1'b0;
      repeat (3) @(negedge clock);
      chk("mid_vld_pre", 32'(mini_dout_vld), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_vld", 32'(mini_dout_vld), 32'd0);
      chk("mid_dout", 32'(mini_dout), 32'd0);
      chk("mid_busy", 32'(rd_busy), 32'd0);
      chk("mid_done", 32'(rd_done), 32'd0);
      chk("mid_err", 32'(rd_lookback_err), 32'd0);
      chk("mid_radr", 32'(fifo_radr_mini), 32'd0);
      chk("mid_wadr", 32'(fifo_wadr_mini), 32'd0);
      chk("mid_wen", 32'(fifo_wen), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_done", 32'(rd_done), 32'd0);
      chk("post_wadr", 32'(fifo_wadr_mini), 32'd0);
      do_read("post", 11'd3, 5'd1, 5'd4, 11'd2044, 1'b0);
      chk("post_err", 32'(rd_lookback_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
